// File: rtl/cache_data_writer_pkg.sv
// cache_writer_pkg: shared FSM state type, sizing constants and merge helpers for cache_data_writer.
// The helpers work at a fixed maximum width. Callers zero-extend their operands
// and truncate the result, so a single function serves every NUM_WAYS/DATA_WIDTH.
package cache_writer_pkg;
  typedef enum logic [1:0] {IDLE, MERGE, WRITE, RESP} state_t;
  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int BYTES_PER_WORD = DEFAULT_DATA_WIDTH / 8;
  localparam int MAX_WAYS = 1024;
  localparam int MAX_DATA_WIDTH = 256;
  localparam int MAX_BYTES = MAX_DATA_WIDTH / 8;
  function automatic logic is_one_hot(input logic [MAX_WAYS-1:0] vector);
    return $onehot(vector);
  endfunction
  function automatic logic [MAX_DATA_WIDTH-1:0] byte_merge(input logic [MAX_DATA_WIDTH-1:0] oldWord,
                                                           input logic [MAX_DATA_WIDTH-1:0] newWord,
                                                           input logic [MAX_BYTES-1:0] byteEn);
    logic [MAX_DATA_WIDTH-1:0] merged;
    for (int b = 0; b < MAX_BYTES; b++) merged[8*b+:8] = byteEn[b] ? newWord[8*b+:8] : oldWord[8*b+:8];
    return merged;
  endfunction
endpackage

// File: rtl/cache_data_writer_if.sv
// cache_data_writer_if: request/response handshake plus way-array write port of the cache data writer.
// master = cache controller and way array side; slave = cache_data_writer.
interface cache_data_writer_if #(parameter int NUM_WAYS = 512, parameter int DATA_WIDTH = 32);
  logic                                 reqValid;
  logic                                 reqReady;
  logic [NUM_WAYS-1:0]                  reqTargetWay;
  logic [DATA_WIDTH-1:0]                reqData;
  logic [DATA_WIDTH/8-1:0]              reqByteEn;
  logic [NUM_WAYS-1:0][DATA_WIDTH-1:0]  wayDataIn;
  logic [NUM_WAYS-1:0]                  wayWriteEn;
  logic [DATA_WIDTH-1:0]                wayWriteData;
  logic                                 respValid;
  logic                                 respReady;
  logic                                 respError;
  modport master(output reqValid, reqTargetWay, reqData, reqByteEn, wayDataIn, respReady,
                 input reqReady, wayWriteEn, wayWriteData, respValid, respError);
  modport slave(input reqValid, reqTargetWay, reqData, reqByteEn, wayDataIn, respReady,
                output reqReady, wayWriteEn, wayWriteData, respValid, respError);
endinterface

// File: rtl/cache_data_writer_read_mux.sv
// cache_way_read_mux: OR-reduces the words of the ways selected by a one-hot vector.
// Ports: sel (way select), wayData (every way's current word), word (selected word).
module cache_way_read_mux #(parameter int NUM_WAYS = 512, parameter int DATA_WIDTH = 32) (
  input  logic [NUM_WAYS-1:0]                 sel,
  input  logic [NUM_WAYS-1:0][DATA_WIDTH-1:0] wayData,
  output logic [DATA_WIDTH-1:0]               word
);
  always_comb begin
    word = '0;
    for (int i = 0; i < NUM_WAYS; i++) word = word | (sel[i] ? wayData[i] : '0);
  end
endmodule

// File: rtl/cache_data_writer.sv
// cache_data_writer: read-modify-write of one cache way word with a completion/error response.
// Ports: clk, reset (async, active-high), bus (slave side of cache_data_writer_if).
module cache_data_writer #(parameter int NUM_WAYS = 512, parameter int DATA_WIDTH = 32) (
  input logic               clk,
  input logic               reset,
  cache_data_writer_if.slave bus
);
  import cache_writer_pkg::*;
  state_t                  state, nextState;
  logic [NUM_WAYS-1:0]     targetReg;
  logic [DATA_WIDTH-1:0]   dataReg, mergedReg, selWord;
  logic [DATA_WIDTH/8-1:0] byteEnReg;
  logic                    errReg, oneHot, accept;
  assign oneHot = is_one_hot(MAX_WAYS'(bus.reqTargetWay));
  assign accept = bus.reqValid && state == IDLE;
  cache_way_read_mux #(.NUM_WAYS(NUM_WAYS), .DATA_WIDTH(DATA_WIDTH)) readMux (
    .sel(targetReg), .wayData(bus.wayDataIn), .word(selWord));
  always_comb begin
    nextState = state == IDLE  ? (!bus.reqValid ? IDLE :
                                  !oneHot || bus.reqByteEn == '0 ? RESP :
                                  &bus.reqByteEn ? WRITE : MERGE) :
                state == MERGE ? WRITE :
                state == WRITE ? RESP :
                bus.respReady  ? IDLE : RESP;
    bus.reqReady = state == IDLE;
    bus.respValid = state == RESP;
    bus.wayWriteEn = state == WRITE ? targetReg : '0;
    bus.wayWriteData = mergedReg;
    bus.respError = errReg;
  end
  // mergedReg is preloaded with reqData on accept, which already is the final word for a full mask;
  // partial masks overwrite it in MERGE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      targetReg <= '0;
      dataReg <= '0;
      byteEnReg <= '0;
      mergedReg <= '0;
      errReg <= 1'b0;
    end else begin
      state <= nextState;
      if (accept) begin
        targetReg <= bus.reqTargetWay;
        dataReg <= bus.reqData;
        byteEnReg <= bus.reqByteEn;
        mergedReg <= bus.reqData;
        errReg <= !oneHot;
      end else if (state == MERGE) begin
        mergedReg <= DATA_WIDTH'(byte_merge(MAX_DATA_WIDTH'(selWord), MAX_DATA_WIDTH'(dataReg),
                                            MAX_BYTES'(byteEnReg)));
      end
      if (state == RESP && bus.respReady) errReg <= 1'b0;
    end
  end
endmodule

// File: tb/tb_cache_data_writer.sv
// tb_cache_data_writer: randomized self-checking bench for cache_data_writer (8 ways, 32-bit words).
module tb_cache_data_writer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int tests = 0;
  int failed = 0;
  cache_data_writer_if #(.NUM_WAYS(8), .DATA_WIDTH(32)) bus ();
  cache_data_writer #(.NUM_WAYS(8), .DATA_WIDTH(32)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

  task automatic scramble_ways();
    for (int i = 0; i < 8; i++) bus.wayDataIn[i] = $urandom;
  endtask

  // Reference: one-hot target with non-empty mask writes at +1 (full) or +2 (partial);
  // response follows the write, or comes at +1 for bad targets and empty masks.
  task automatic run_txn(input logic [7:0] tgt, input logic [31:0] dat, input logic [3:0] be);
    logic err, noop;
    int wc, rc;
    logic [31:0] sel, mask, expWord;
    err = $countones(tgt) != 1;
    noop = be == 4'h0;
    wc = (err || noop) ? 0 : (be == 4'hF ? 1 : 2);
    rc = (err || noop) ? 1 : wc + 1;
    sel = 32'h0;
    for (int i = 0; i < 8; i++) if (tgt[i]) sel = bus.wayDataIn[i];
    for (int b = 0; b < 4; b++) mask[8*b+:8] = {8{be[b]}};
    expWord = (dat & mask) | (sel & ~mask);
    @(negedge clk);
    bus.reqValid = 1'b1;
    bus.reqTargetWay = tgt;
    bus.reqData = dat;
    bus.reqByteEn = be;
    tests++;
    if (bus.reqReady !== 1'b1) begin failed++; $display("FAIL accept_ready: reqReady=%b required 1", bus.reqReady); end
    @(posedge clk);
    #1 bus.reqValid = 1'b0;
    bus.reqData = $urandom;
    for (int k = 1; k <= rc; k++) begin
      @(negedge clk);
      tests++;
      if (bus.wayWriteEn !== (k == wc ? tgt : 8'h0)) begin
        failed++; $display("FAIL write_en +%0d: got %h required %h (tgt=%h be=%h)", k, bus.wayWriteEn, k == wc ? tgt : 8'h0, tgt, be);
      end
      if (k == wc) begin
        tests++;
        if (bus.wayWriteData !== expWord) begin
          failed++; $display("FAIL write_data +%0d: got %h required %h (be=%h)", k, bus.wayWriteData, expWord, be);
        end
      end
      tests++;
      if (bus.respValid !== (k == rc)) begin
        failed++; $display("FAIL resp_valid +%0d: got %b required %b (tgt=%h be=%h)", k, bus.respValid, k == rc, tgt, be);
      end
      if (k == rc) begin
        tests++;
        if (bus.respError !== err) begin failed++; $display("FAIL resp_error: got %b required %b (tgt=%h)", bus.respError, err, tgt); end
      end
      tests++;
      if (bus.reqReady !== 1'b0) begin failed++; $display("FAIL busy_ready +%0d: got %b required 0", k, bus.reqReady); end
      if (!(k == 1 && wc == 2)) scramble_ways();
    end
    @(negedge clk);
    tests++;
    if (bus.reqReady !== 1'b1 || bus.respValid !== 1'b0 || bus.wayWriteEn !== 8'h0) begin
      failed++; $display("FAIL back_to_idle: ready=%b respValid=%b wen=%h required 1/0/00", bus.reqReady, bus.respValid, bus.wayWriteEn);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    tests++;
    if (bus.reqReady !== 1'b1 || bus.wayWriteEn !== 8'h0 || bus.wayWriteData !== 32'h0 ||
        bus.respValid !== 1'b0 || bus.respError !== 1'b0) begin
      failed++;
      $display("FAIL %s: ready=%b wen=%h wdata=%h respValid=%b respError=%b required 1/00/00000000/0/0",
               tag, bus.reqReady, bus.wayWriteEn, bus.wayWriteData, bus.respValid, bus.respError);
    end
  endtask

  task automatic test_reset();
    check_reset_outputs("reset_in");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_reset_outputs("reset_after");
  endtask

  task automatic test_full_mask();
    scramble_ways();
    bus.wayDataIn[3] = 32'h11223344;
    run_txn(8'h08, 32'hAABBCCDD, 4'hF);
  endtask

  task automatic test_partial_merge();
    scramble_ways();
    bus.wayDataIn[5] = 32'h11223344;
    run_txn(8'h20, 32'hAABBCCDD, 4'h5);
  endtask

  task automatic test_bad_target();
    run_txn(8'h00, 32'h12345678, 4'hF);
    run_txn(8'h0C, 32'h87654321, 4'h3);
  endtask

  task automatic test_zero_mask();
    run_txn(8'h01, 32'hDEADBEEF, 4'h0);
  endtask

  task automatic test_backpressure();
    logic [31:0] dataB;
    dataB = $urandom;
    @(negedge clk);
    bus.respReady = 1'b0;
    bus.reqValid = 1'b1;
    bus.reqTargetWay = 8'h02;
    bus.reqData = 32'hCAFEF00D;
    bus.reqByteEn = 4'hF;
    @(posedge clk);
    #1 bus.reqTargetWay = 8'h40;
    bus.reqData = dataB;
    bus.reqByteEn = 4'h3;
    @(negedge clk);
    tests++;
    if (bus.wayWriteEn !== 8'h02 || bus.wayWriteData !== 32'hCAFEF00D) begin
      failed++; $display("FAIL bp_write: wen=%h data=%h required 02/cafef00d", bus.wayWriteEn, bus.wayWriteData);
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      tests++;
      if (bus.respValid !== 1'b1 || bus.reqReady !== 1'b0 || bus.wayWriteEn !== 8'h0 || bus.respError !== 1'b0) begin
        failed++; $display("FAIL bp_hold %0d: respValid=%b ready=%b wen=%h err=%b required 1/0/00/0", k, bus.respValid, bus.reqReady, bus.wayWriteEn, bus.respError);
      end
    end
    bus.respReady = 1'b1;
    run_txn(8'h40, dataB, 4'h3);
  endtask

  task automatic test_reset_mid_op();
    scramble_ways();
    @(negedge clk);
    bus.reqValid = 1'b1;
    bus.reqTargetWay = 8'h10;
    bus.reqData = 32'h55667788;
    bus.reqByteEn = 4'h6;
    @(posedge clk);
    #1 bus.reqValid = 1'b0;
    @(negedge clk);
    tests++;
    if (bus.reqReady !== 1'b0 || bus.wayWriteEn !== 8'h0) begin
      failed++; $display("FAIL mid_merge: ready=%b wen=%h required 0/00", bus.reqReady, bus.wayWriteEn);
    end
    #2 reset = 1'b1;
    #1 check_reset_outputs("reset_async");
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_reset_outputs("reset_held");
    end
    reset = 1'b0;
    scramble_ways();
    run_txn(8'h10, 32'h55667788, 4'h6);
  endtask

  task automatic test_random();
    logic [7:0] tgt;
    for (int n = 0; n < 40; n++) begin
      scramble_ways();
      tgt = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'(1 << $urandom_range(0, 7));
      run_txn(tgt, $urandom, 4'($urandom));
    end
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 4; n++) run_txn(8'(1 << n), $urandom, 4'(n + 9));
  endtask

  initial begin
    bus.reqValid = 1'b0;
    bus.reqTargetWay = 8'h0;
    bus.reqData = 32'h0;
    bus.reqByteEn = 4'h0;
    bus.respReady = 1'b1;
    for (int i = 0; i < 8; i++) bus.wayDataIn[i] = 32'h0;
    @(negedge clk);
    test_reset();
    test_full_mask();
    test_partial_merge();
    test_bad_target();
    test_zero_mask();
    test_backpressure();
    test_reset_mid_op();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule

// File: doc/cache_data_writer.md
Name: cache_data_writer

Overview:
- Write-side counterpart of the cache hit-data fetch path. Accepts one write request per transaction, addressed to a single way by a one-hot way vector.
- Merges the request bytes into the way's current word (read-modify-write) and pulses a per-way write enable.
- Returns a completion or error response to the cache controller.
- Sits between the cache controller (store hits, refill writes) and the way storage array.

Parameters:
- NUM_WAYS, 512, number of ways, one write-enable bit per way.
- DATA_WIDTH, 32, word width in bits; must be a multiple of 8.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- reqValid  input  1  write request valid.
- reqReady  output  1  block can accept a request.
- reqTargetWay  input  NUM_WAYS  one-hot way select.
- reqData  input  DATA_WIDTH  write data.
- reqByteEn  input  DATA_WIDTH/8  byte enables; bit b covers bits [8b+7:8b].
- wayDataIn  input  NUM_WAYS x DATA_WIDTH  current dataOut of each way.
- wayWriteEn  output  NUM_WAYS  per-way write strobe.
- wayWriteData  output  DATA_WIDTH  merged word, broadcast to all ways.
- respValid  output  1  response valid.
- respReady  input  1  response accepted.
- respError  output  1  target vector was not one-hot; qualified by respValid.

Behaviour:
- Reset values: state IDLE, reqReady=1, wayWriteEn=0, wayWriteData=0, respValid=0, respError=0. All internal registers cleared.
- States and outputs:
  - IDLE: reqReady=1; all other strobes 0.
  - MERGE: reqReady=0.
  - WRITE: wayWriteEn = registered target vector for exactly one cycle; wayWriteData = merged word.
  - RESP: respValid=1, held until respReady.
- Accept: reqValid && reqReady at a rising edge. Target, data and byteEn are registered. One-hot check is computed on the input vector, and its result is registered.
- Transitions from IDLE on accept:
  - Target not one-hot (zero or multiple bits): go to RESP with respError=1. No write occurs.
  - byteEn all zero: go to RESP with respError=0. No write occurs.
  - byteEn all ones: go to WRITE; merged word = reqData.
  - Otherwise: go to MERGE.
- MERGE: selected word = OR of wayDataIn[i] over the registered target bits. Per byte: merged = byteEn ? reqData : selected. The merged word is registered. Next state is WRITE.
- WRITE: next state is RESP, respError=0.
- RESP: on respValid && respReady, go to IDLE and clear respError. reqReady returns to 1 in the following cycle. No back-to-back overlap.
- Latency, counted from the accept edge:
  - Partial mask: write cycle +2, response cycle +3.
  - Full mask: write +1, response +2.
  - Error or no-op: response +1.
- wayWriteEn is decoded from the state register, not from inputs. It is glitch-free and never asserted outside WRITE.
- wayDataIn is sampled only in MERGE. Changes in other cycles are ignored.
- reqValid while busy: not accepted, no effect. The requester holds the request.
- Reset asserted mid-operation: state forced to IDLE immediately (asynchronous). wayWriteEn drops to 0 in the same cycle, so no partial write is issued. Any pending response is discarded.

Decomposition:
- Package cache_writer_pkg:
  - state enum: IDLE, MERGE, WRITE, RESP.
  - localparam BYTES_PER_WORD = DATA_WIDTH/8.
  - function is_one_hot(vector).
  - function byte_merge(old, new, byteEn).
- Sub-module cache_way_read_mux: one-hot-qualified OR-reduction of wayDataIn. It is purely combinational, reusable, and keeps the FSM file small.
- FSM, registers and merge stay in cache_data_writer.

Test Plan (NUM_WAYS=8, DATA_WIDTH=32):
- Full-mask write: way 3 = 0x11223344; request target=0x08, data=0xAABBCCDD, byteEn=0xF. Required: wayWriteEn=0x08 for one cycle at accept+1 with wayWriteData=0xAABBCCDD; respValid at +2, respError=0.
- Partial merge: way 5 = 0x11223344; request target=0x20, data=0xAABBCCDD, byteEn=0x5. Required: wayWriteData=0x11BB33DD, wayWriteEn=0x20 at +2; respValid at +3.
- Bad target: target=0x00, then target=0x0C. Required in each case: respValid at +1 with respError=1; wayWriteEn stays 0 throughout.
- Response backpressure: respReady=0 for 4 cycles while a second request is held valid. Required: respValid held; reqReady=0; second request accepted only the cycle after respReady=1.
- Reset mid-op: assert reset during MERGE of a partial write. Required: wayWriteEn never asserted; all outputs at reset values immediately; first request after deassertion behaves normally.
- Zero mask: byteEn=0x0, target=0x01. Required: respValid at +1, respError=0, no write strobe.
